// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: direct-mapped BHT of 2-bit saturating counters plus a
// tagged BTB. Lookup is combinational from pc; resolved branches write back
// through the update port and become visible one clock later. After reset an
// init sequencer walks every entry, so the tables themselves carry no reset.
// Optional macro BP_GSHARE_EN: XOR a global history register into the
// counter index (gshare). Default build is pure bimodal.
module branch_predictor_bht #(
   parameter int          ADDR_WIDTH = 32,
   parameter int          INDEX_BITS = 6,
   parameter int          TAG_BITS   = 8,
   parameter int          HIST_BITS  = 6,
   parameter logic [1:0]  CTR_INIT   = 2'b01
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] pc,
   output logic                  predict_taken,
   output logic [ADDR_WIDTH-1:0] predict_target,
   output logic                  predict_hit,
   output logic [HIST_BITS-1:0]  pred_hist,
   input  logic                  upd_valid,
   input  logic [ADDR_WIDTH-1:0] upd_pc,
   input  logic                  upd_taken,
   input  logic [ADDR_WIDTH-1:0] upd_target,
   input  logic [HIST_BITS-1:0]  upd_hist,
   output logic                  ready
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                  state_reg;
   logic [INDEX_BITS-1:0]   ptr_reg;
   logic                    ready_reg;

   logic [1:0]              ctr_mem        [ENTRIES];
   logic [ENTRIES-1:0]      btb_valid_reg;
   logic [TAG_BITS-1:0]     btb_tag_mem    [ENTRIES];
   logic [ADDR_WIDTH-1:0]   btb_target_mem [ENTRIES];

   logic [INDEX_BITS-1:0]   li, ui, ci, cu;
   logic [TAG_BITS-1:0]     lt, ut;
   logic [1:0]              ctr_cur, ctr_next;
   logic                    hit;
   logic                    upd_en;

   assign li = pc[INDEX_BITS+1:2];
   assign lt = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
   assign ui = upd_pc[INDEX_BITS+1:2];
   assign ut = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

   // Updates are only honoured once the tables are initialised.
   assign upd_en = upd_valid && (state_reg == ST_RUN) && !reset;

`ifdef BP_GSHARE_EN
   logic [HIST_BITS-1:0] ghr_reg;

   // Global history shifts in every resolved outcome while running.
   always_ff @(posedge clk) begin
      if (reset)
         ghr_reg <= '0;
      else if (upd_en)
         ghr_reg <= {ghr_reg[HIST_BITS-2:0], upd_taken};
   end

   assign ci        = li ^ INDEX_BITS'(ghr_reg);
   assign cu        = ui ^ INDEX_BITS'(upd_hist);
   assign pred_hist = ghr_reg;

   logic unused_bits;
   assign unused_bits = ^{upd_pc[ADDR_WIDTH-1:INDEX_BITS+TAG_BITS+2], upd_pc[1:0]};
`else
   assign ci        = li;
   assign cu        = ui;
   assign pred_hist = '0;

   logic unused_bits;
   assign unused_bits = ^{upd_pc[ADDR_WIDTH-1:INDEX_BITS+TAG_BITS+2], upd_pc[1:0], upd_hist};
`endif

   // Init sequencer: one entry per cycle, then RUN; reset always restarts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_INIT;
         ptr_reg   <= '0;
         ready_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_INIT: begin
               ptr_reg <= ptr_reg + INDEX_BITS'(1);
               if (ptr_reg == INDEX_BITS'(ENTRIES - 1)) begin
                  state_reg <= ST_RUN;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= ST_RUN;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign ready = ready_reg;

   // Saturating counter step for the entry being updated.
   always_comb begin
      ctr_cur  = ctr_mem[cu];
      ctr_next = ctr_cur;
      if (upd_taken) begin
         if (ctr_cur != 2'b11)
            ctr_next = ctr_cur + 2'b01;
      end else begin
         if (ctr_cur != 2'b00)
            ctr_next = ctr_cur - 2'b01;
      end
   end

   // Table writes: init clears one entry per cycle, RUN applies resolved branches.
   always_ff @(posedge clk) begin
      if (!reset && state_reg == ST_INIT) begin
         ctr_mem[ptr_reg]       <= CTR_INIT;
         btb_valid_reg[ptr_reg] <= 1'b0;
      end else if (upd_en) begin
         ctr_mem[cu] <= ctr_next;
         if (upd_taken) begin
            btb_valid_reg[ui]  <= 1'b1;
            btb_tag_mem[ui]    <= ut;
            btb_target_mem[ui] <= upd_target;
         end
      end
   end

   // Same-cycle lookup; reads the tables as they stand before this edge's update.
   always_comb begin
      hit            = (state_reg == ST_RUN) && btb_valid_reg[li] && (btb_tag_mem[li] == lt);
      predict_hit    = hit;
      predict_taken  = hit && ctr_mem[ci][1];
      predict_target = predict_taken ? btb_target_mem[li] : pc + ADDR_WIDTH'(4);
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed self-checking bench for branch_predictor_bht (default parameters).
module tb_branch_predictor_bht;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = '0;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic        predict_hit;
   logic [5:0]  pred_hist;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic [5:0]  upd_hist = '0;
   logic        ready;

   int n_cmp = 0;
   int n_fail = 0;

   branch_predictor_bht dut (
      .clk            (clk),
      .reset          (reset),
      .pc             (pc),
      .predict_taken  (predict_taken),
      .predict_target (predict_target),
      .predict_hit    (predict_hit),
      .pred_hist      (pred_hist),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_hist       (upd_hist),
      .ready          (ready)
   );

   always #5 clk = ~clk;

   // One update transaction; called just after a negedge, returns at the next one.
   task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tgt,
                      input logic [5:0] h);
      upd_valid  = 1'b1;
      upd_pc     = a;
      upd_taken  = t;
      upd_target = tgt;
      upd_hist   = h;
      @(negedge clk);
      upd_valid  = 1'b0;
      $display("upd pc=%h taken=%0d target=%h hist=%h", a, t, tgt, h);
   endtask

   // Pulse reset for one cycle and wait (bounded) for init to finish.
   task automatic do_reset();
      int n;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (ready !== 1'b1) begin
         $display("FAIL do_reset_timeout ready=%b required=1", ready);
         n_fail++;
      end
   endtask

   task automatic test_reset();
      int cnt;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cnt = 0;
      while (!ready && cnt < 200) begin
         cnt++;
         pc = (cnt == 10) ? 32'hFFFF_FFFC : (32'(cnt) << 2);
         #1;
         n_cmp++;
         if (predict_taken !== 1'b0 || predict_hit !== 1'b0 || predict_target !== pc + 32'd4) begin
            $display("FAIL init_predict pc=%h taken=%b hit=%b target=%h required 0/0/%h",
                     pc, predict_taken, predict_hit, predict_target, pc + 32'd4);
            n_fail++;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (cnt !== 64) begin
         $display("FAIL init_duration cycles=%0d required=64", cnt);
         n_fail++;
      end
      $display("init finished after %0d cycles", cnt);
      for (int i = 0; i < 64; i++) begin
         pc = 32'h0000_1000 + (32'(i) << 2);
         #1;
         n_cmp++;
         if (predict_taken !== 1'b0 || predict_hit !== 1'b0 || predict_target !== pc + 32'd4) begin
            $display("FAIL post_init_predict pc=%h taken=%b hit=%b target=%h required 0/0/%h",
                     pc, predict_taken, predict_hit, predict_target, pc + 32'd4);
            n_fail++;
         end
      end
      n_cmp++;
      if (pred_hist !== 6'd0) begin
         $display("FAIL reset_hist pred_hist=%h required=00", pred_hist);
         n_fail++;
      end
   endtask

   task automatic test_training();
      do_reset();
      pc = 32'h100;
      #1;
      n_cmp++;
      if (predict_hit !== 1'b0) begin
         $display("FAIL train_cold_hit hit=%b required=0", predict_hit);
         n_fail++;
      end
      upd(32'h100, 1'b1, 32'h200, 6'd0);
      upd(32'h100, 1'b1, 32'h200, 6'd0);
      n_cmp++;
      if (predict_taken !== 1'b1 || predict_hit !== 1'b1 || predict_target !== 32'h200) begin
         $display("FAIL train_taken taken=%b hit=%b target=%h required 1/1/00000200",
                  predict_taken, predict_hit, predict_target);
         n_fail++;
      end
      for (int i = 0; i < 3; i++) upd(32'h100, 1'b1, 32'h200, 6'd0);
      upd(32'h100, 1'b0, 32'h0, 6'd0);
      n_cmp++;
      if (predict_taken !== 1'b1) begin
         $display("FAIL train_sat_high taken=%b required=1", predict_taken);
         n_fail++;
      end
      upd(32'h100, 1'b0, 32'h0, 6'd0);
      n_cmp++;
      if (predict_taken !== 1'b0 || predict_hit !== 1'b1 || predict_target !== 32'h104) begin
         $display("FAIL train_nt taken=%b hit=%b target=%h required 0/1/00000104",
                  predict_taken, predict_hit, predict_target);
         n_fail++;
      end
      for (int i = 0; i < 3; i++) upd(32'h100, 1'b0, 32'h0, 6'd0);
      upd(32'h100, 1'b1, 32'h200, 6'd0);
      n_cmp++;
      if (predict_taken !== 1'b0) begin
         $display("FAIL train_sat_low taken=%b required=0", predict_taken);
         n_fail++;
      end
      upd(32'h100, 1'b1, 32'h200, 6'd0);
      n_cmp++;
      if (predict_taken !== 1'b1 || predict_target !== 32'h200) begin
         $display("FAIL train_recover taken=%b target=%h required 1/00000200",
                  predict_taken, predict_target);
         n_fail++;
      end
   endtask

   task automatic test_alias();
      do_reset();
      upd(32'h100, 1'b1, 32'h300, 6'd0);
      upd(32'h100, 1'b1, 32'h300, 6'd0);
      pc = 32'h200;
      #1;
      n_cmp++;
      if (predict_hit !== 1'b0 || predict_taken !== 1'b0 || predict_target !== 32'h204) begin
         $display("FAIL alias_miss hit=%b taken=%b target=%h required 0/0/00000204",
                  predict_hit, predict_taken, predict_target);
         n_fail++;
      end
      upd(32'h200, 1'b1, 32'h400, 6'd0);
      n_cmp++;
      if (predict_hit !== 1'b1 || predict_taken !== 1'b1 || predict_target !== 32'h400) begin
         $display("FAIL alias_new hit=%b taken=%b target=%h required 1/1/00000400",
                  predict_hit, predict_taken, predict_target);
         n_fail++;
      end
      pc = 32'h100;
      #1;
      n_cmp++;
      if (predict_hit !== 1'b0 || predict_target !== 32'h104) begin
         $display("FAIL alias_evicted hit=%b target=%h required 0/00000104",
                  predict_hit, predict_target);
         n_fail++;
      end
   endtask

   // Continues from test_alias: index 0 holds tag of 0x200, ctr = 11.
   task automatic test_back_to_back();
      pc         = 32'h100;
      upd_valid  = 1'b1;
      upd_pc     = 32'h100;
      upd_taken  = 1'b1;
      upd_target = 32'h500;
      upd_hist   = 6'd0;
      #1;
      n_cmp++;
      if (predict_hit !== 1'b0) begin
         $display("FAIL collide_old_hit hit=%b required=0", predict_hit);
         n_fail++;
      end
      @(negedge clk);
      upd_valid = 1'b0;
      $display("upd pc=00000100 taken=1 target=00000500 (same-cycle lookup)");
      n_cmp++;
      if (predict_hit !== 1'b1 || predict_taken !== 1'b1 || predict_target !== 32'h500) begin
         $display("FAIL collide_new hit=%b taken=%b target=%h required 1/1/00000500",
                  predict_hit, predict_taken, predict_target);
         n_fail++;
      end
      // Two not-taken collisions: 11 -> 10 -> 01.
      for (int i = 0; i < 2; i++) begin
         upd_valid = 1'b1;
         upd_taken = 1'b0;
         #1;
         n_cmp++;
         if (predict_taken !== 1'b1) begin
            $display("FAIL collide_nt_old_%0d taken=%b required=1", i, predict_taken);
            n_fail++;
         end
         @(negedge clk);
         upd_valid = 1'b0;
         $display("upd pc=00000100 taken=0 (same-cycle lookup)");
      end
      n_cmp++;
      if (predict_taken !== 1'b0 || predict_hit !== 1'b1) begin
         $display("FAIL collide_nt_new taken=%b hit=%b required 0/1", predict_taken, predict_hit);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid_run();
      int cnt;
      do_reset();
      upd(32'h100, 1'b1, 32'h700, 6'd0);
      upd(32'h100, 1'b1, 32'h700, 6'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if (ready !== 1'b0) begin
         $display("FAIL midrun_ready ready=%b required=0", ready);
         n_fail++;
      end
      upd_valid  = 1'b1;
      upd_pc     = 32'h100;
      upd_taken  = 1'b1;
      upd_target = 32'h600;
      cnt = 0;
      while (!ready && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      upd_valid = 1'b0;
      n_cmp++;
      if (cnt !== 64) begin
         $display("FAIL midrun_init_duration cycles=%0d required=64", cnt);
         n_fail++;
      end
      pc = 32'h100;
      #1;
      n_cmp++;
      if (predict_hit !== 1'b0 || predict_taken !== 1'b0 || predict_target !== 32'h104) begin
         $display("FAIL midrun_cleared hit=%b taken=%b target=%h required 0/0/00000104",
                  predict_hit, predict_taken, predict_target);
         n_fail++;
      end
      // Counter must be back at 01: one taken update makes it 10.
      upd(32'h100, 1'b1, 32'h800, 6'd0);
      n_cmp++;
      if (predict_taken !== 1'b1 || predict_target !== 32'h800) begin
         $display("FAIL midrun_ctr_init taken=%b target=%h required 1/00000800",
                  predict_taken, predict_target);
         n_fail++;
      end
   endtask

`ifdef BP_GSHARE_EN
   task automatic test_gshare();
      do_reset();
      pc = 32'h100;
      upd(32'h100, 1'b1, 32'h900, 6'd3);
      upd(32'h100, 1'b1, 32'h900, 6'd3);
      n_cmp++;
      if (pred_hist !== 6'b000011) begin
         $display("FAIL gshare_hist pred_hist=%b required=000011", pred_hist);
         n_fail++;
      end
      n_cmp++;
      if (predict_taken !== 1'b1 || predict_target !== 32'h900) begin
         $display("FAIL gshare_lookup taken=%b target=%h required 1/00000900",
                  predict_taken, predict_target);
         n_fail++;
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef BP_GSHARE_EN
      test_gshare();
`else
      test_training();
      test_alias();
      test_back_to_back();
      test_reset_mid_run();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised successor to the single-entry predictor in the pipelined datapath.
- Direct-mapped branch history table of 2-bit saturating counters plus a tagged branch target buffer (BTB).
- Fetch does a same-cycle lookup on the current PC. The EX/MEM branch resolution writes back through a separate update port.
- A post-reset init sequencer clears the tables, so no large reset fan-out is needed.

Parameters:
- ADDR_WIDTH, 32, PC width in bits.
- INDEX_BITS, 6, log2 of table entries; ENTRIES = 2**INDEX_BITS.
- TAG_BITS, 8, BTB tag width, taken from pc[INDEX_BITS+TAG_BITS+1 : INDEX_BITS+2].
- HIST_BITS, 6, global history length (used only with GSHARE_EN); must be <= INDEX_BITS.
- CTR_INIT, 2'b01, counter value written during init (weakly not-taken).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- pc  input  ADDR_WIDTH  fetch PC for lookup.
- predict_taken  output  1  prediction for pc (combinational).
- predict_target  output  ADDR_WIDTH  predicted next PC (combinational).
- predict_hit  output  1  BTB hit for pc.
- pred_hist  output  HIST_BITS  history snapshot; the pipeline carries it to EX.
- upd_valid  input  1  resolved branch present this cycle.
- upd_pc  input  ADDR_WIDTH  PC of the resolved branch.
- upd_taken  input  1  actual outcome.
- upd_target  input  ADDR_WIDTH  actual taken target.
- upd_hist  input  HIST_BITS  pred_hist value captured at lookup time.
- ready  output  1  init finished; predictions valid.

Behaviour:
- Index and tag
  - Lookup index li = pc[INDEX_BITS+1:2]; update index ui = upd_pc[INDEX_BITS+1:2].
  - pc[1:0] is ignored.
- Reset (synchronous, active-high)
  - FSM goes to INIT; init pointer = 0; ready = 0.
  - Reset asserted mid-INIT or mid-RUN restarts INIT from pointer 0.
- INIT state
  - Each cycle: ctr[ptr] <= CTR_INIT, btb_valid[ptr] <= 0, ptr increments.
  - When ptr == ENTRIES-1 is written, next state is RUN. INIT lasts exactly ENTRIES cycles.
  - Outputs during INIT: predict_taken = 0, predict_hit = 0, predict_target = pc+4.
  - upd_valid is ignored during INIT.
- RUN state
  - ready = 1.
  - hit = btb_valid[li] && btb_tag[li] == pc tag.
  - predict_hit = hit; predict_taken = hit && ctr[li][1].
  - predict_target = btb_target[li] when predict_taken, else pc+4 (modulo 2**ADDR_WIDTH wrap).
- Update, on posedge when upd_valid in RUN
  - Counter: upd_taken increments ctr[ui] (saturates at 11); otherwise decrements (saturates at 00).
  - upd_taken = 1: btb_valid[ui] <= 1, btb_tag[ui] <= upd_pc tag, btb_target[ui] <= upd_target. An existing entry with a different tag is overwritten.
  - upd_taken = 0: BTB entry untouched.
- Simultaneous lookup and update to the same index
  - Lookup returns the pre-update value (read-before-write).
  - The new value is visible the next cycle.
- Latency: lookup is 0 cycles (combinational from pc); update takes effect after 1 clock.
- Tables are flop arrays with no read port delay. No bypass from the update port to the lookup port.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - A HIST_BITS global history register (ghr) resets to 0 on reset.
  - On each RUN upd_valid: ghr <= {ghr[HIST_BITS-2:0], upd_taken}.
  - Counter lookup index = li XOR zero-extended ghr; counter update index = ui XOR zero-extended upd_hist.
  - pred_hist = ghr.
  - BTB indexing remains pc-only.
- Undefined:
  - Pure bimodal; no ghr.
  - pred_hist is driven to 0; upd_hist is ignored.

Test Plan:
- INIT duration: reset high for 1 cycle, then low -> ready = 0 for exactly 64 cycles, then 1; every pc predicts not-taken with target pc+4.
- Counter training and saturation: pc = 0x100; two taken updates with target 0x200 -> predict_taken = 1, predict_target = 0x200. Three further taken updates keep ctr = 11. Two not-taken updates -> predict_taken = 0, predict_hit = 1.
- Alias and tag miss: train 0x100 taken, then look up 0x100 + (64<<2) = 0x200 (same index, different tag) -> predict_hit = 0, target 0x204. A taken update at 0x200 then evicts 0x100 -> 0x100 misses.
- Same-cycle collision: lookup and update at 0x100 in one cycle -> old prediction that cycle, updated prediction the next.
- Reset mid-run: trained table, assert reset one cycle -> ready = 0, and after 64 cycles all predictions are not-taken; upd_valid during INIT has no effect.
- BP_GSHARE_EN: updates at 0x100 taken, taken -> pred_hist = 6'b000011; lookup at 0x100 uses index 0x00 XOR 0x03 = 0x03, and counter entry 3 carries the trained state.
